vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Purpose: 640x480 raster timing generator (coordinates, syncs, display enable, frame pulse).
// Latency: outputs are registered one cycle behind the internal h/v counters, all mutually aligned.
// Backpressure: none; free-running every pixel clock. Optional frameCount port via VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               hSync,
  output logic               vSync,
  output logic               displayEnable,
  output logic               startOfFrame
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]         frameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic       hWrap;
  logic       vWrap;
  logic       hSyncWin;
  logic       vSyncWin;

  assign hWrap    = (hCnt == H_LAST);
  assign vWrap    = (vCnt == V_LAST);
  assign hSyncWin = (hCnt >= HS_START) && (hCnt < HS_END);
  // vCnt only moves on the line wrap, so vSync naturally changes at hCnt == 0.
  assign vSyncWin = (vCnt >= VS_START) && (vCnt < VS_END);

  // Raster counters: column every clock, line on column wrap, both wrap together at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hWrap) begin
      hCnt <= '0;
      vCnt <= vWrap ? '0 : vCnt + 10'd1;
    end else begin
      hCnt <= hCnt + 10'd1;
    end
  end

  // Output registers decoded from the current counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixelX        <= '0;
      pixelY        <= '0;
      hSync         <= ~SYNC_ACTIVE;
      vSync         <= ~SYNC_ACTIVE;
      displayEnable <= 1'b0;
      startOfFrame  <= 1'b0;
    end else begin
      pixelX        <= $signed({1'b0, hCnt});
      pixelY        <= $signed({1'b0, vCnt});
      hSync         <= hSyncWin ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vSync         <= vSyncWin ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      displayEnable <= (hCnt < H_VIS_END) && (vCnt < V_VIS_END);
      startOfFrame  <= (hCnt == 10'd0) && (vCnt == 10'd0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Completed-frame counter; bumps on the frame-wrap edge so it is already updated
  // when the next startOfFrame pulse appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameCount <= 8'd0;
    end else if (hWrap && vWrap) begin
      frameCount <= frameCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (18x10 total) so many frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HV = 10, HF = 2, HS = 4, HB = 2;
  localparam int VV = 5,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [10:0] pixelX, pixelY;
  logic hSync, vSync, displayEnable, startOfFrame;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frameCount;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .hSync(hSync),
    .vSync(vSync),
    .displayEnable(displayEnable),
    .startOfFrame(startOfFrame)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frameCount(frameCount)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: number of rising edges since reset release; everything derives from it.
  int n = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Per-cycle comparison against the arithmetic model, plus literal period/width checks.
  int cyc = 0;
  int last_sof = -1;
  int hrun = 0, vrun = 0;
  bit hvalid = 0, vvalid = 0;
  logic prev_h = 1'b1, prev_v = 1'b1;
  always @(negedge clk) begin
    int k, px, py, efc;
    logic ehs, evs, ede, esof;
    cyc++;
    if (reset || n == 0) begin
      px = 0; py = 0; ehs = 1'b1; evs = 1'b1; ede = 1'b0; esof = 1'b0;
    end else begin
      k    = (n - 1) % FT;
      px   = k % HT;
      py   = k / HT;
      ehs  = !(px >= HV + HF && px < HV + HF + HS);
      evs  = !(py >= VV + VF && py < VV + VF + VS);
      ede  = (px < HV) && (py < VV);
      esof = (px == 0) && (py == 0);
    end
    chk("pixelX", 32'(pixelX), 32'(px));
    chk("pixelY", 32'(pixelY), 32'(py));
    chk("hSync", {31'd0, hSync}, {31'd0, ehs});
    chk("vSync", {31'd0, vSync}, {31'd0, evs});
    chk("displayEnable", {31'd0, displayEnable}, {31'd0, ede});
    chk("startOfFrame", {31'd0, startOfFrame}, {31'd0, esof});
`ifdef VGA_FRAME_COUNT_EN
    efc = reset ? 0 : (n / FT) % 256;
    chk("frameCount", {24'd0, frameCount}, 32'(efc));
`else
    efc = 0;
`endif
    if (reset) begin
      last_sof = -1; hvalid = 0; vvalid = 0;
    end else begin
      if (startOfFrame) begin
        if (last_sof >= 0) chk("sof_period", 32'(cyc - last_sof), 32'd180);
        last_sof = cyc;
      end
      if (!hSync && prev_h) begin hrun = 1; hvalid = 1; end
      else if (!hSync) hrun++;
      else if (!prev_h && hvalid) chk("hsync_width", 32'(hrun), 32'd4);
      if (!vSync && prev_v) begin vrun = 1; vvalid = 1; end
      else if (!vSync) vrun++;
      else if (!prev_v && vvalid) chk("vsync_width", 32'(vrun), 32'd36);
    end
    prev_h = hSync;
    prev_v = vSync;
  end

  // Advance to the edge where outputs show (x,y); bounded.
  task automatic wait_pos(input int x, input int y, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (pixelX == 11'(x) && pixelY == 11'(y)) found = 1;
    end
    if (!found) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_immediate_px", 32'(pixelX), 32'd0);
    chk("rst_immediate_sof", {31'd0, startOfFrame}, 32'd0);
    chk("rst_immediate_hs", {31'd0, hSync}, 32'd1);
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // First two edges after release.
    @(posedge clk); #1;
    chk("first_px", 32'(pixelX), 32'd0);
    chk("first_py", 32'(pixelY), 32'd0);
    chk("first_sof", {31'd0, startOfFrame}, 32'd1);
    chk("first_de", {31'd0, displayEnable}, 32'd1);
    @(posedge clk); #1;
    chk("second_px", 32'(pixelX), 32'd1);
    chk("second_sof", {31'd0, startOfFrame}, 32'd0);

    // Visible edge of the line and line wrap.
    wait_pos(HV, 0, 2 * HT);
    chk("de_falls", {31'd0, displayEnable}, 32'd0);
    wait_pos(HT - 1, 0, 2 * HT);
    @(posedge clk); #1;
    chk("line_wrap_px", 32'(pixelX), 32'd0);
    chk("line_wrap_py", 32'(pixelY), 32'd1);

    // Frame wrap.
    wait_pos(HT - 1, VT - 1, 2 * FT);
    @(posedge clk); #1;
    chk("frame_wrap_py", 32'(pixelY), 32'd0);
    chk("frame_wrap_sof", {31'd0, startOfFrame}, 32'd1);

    // Mid-frame reset, then next frame from (0,0).
    wait_pos(5, 3, 2 * FT);
    do_reset(3);
    @(posedge clk); #1;
    chk("post_rst_px", 32'(pixelX), 32'd0);
    chk("post_rst_sof", {31'd0, startOfFrame}, 32'd1);
    repeat (2 * FT + 7) @(posedge clk);

    // Randomized run lengths and reset pulses.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(1, 3 * FT)) @(posedge clk);
      do_reset($urandom_range(1, 4));
    end
    repeat (3 * FT) @(posedge clk);

`ifdef VGA_FRAME_COUNT_EN
    do_reset(2);
    for (int f = 1; f <= 257; f++) begin
      bit seen;
      seen = 0;
      for (int i = 0; i < FT + 2 && !seen; i++) begin
        @(posedge clk); #1;
        if (startOfFrame) seen = 1;
      end
      if (!seen) chk("sof_timeout", 32'd0, 32'd1);
      if (f == 2)   chk("fc_at_sof2",   {24'd0, frameCount}, 32'd1);
      if (f == 256) chk("fc_at_sof256", {24'd0, frameCount}, 32'd255);
      if (f == 257) chk("fc_at_sof257", {24'd0, frameCount}, 32'd0);
    end
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
